// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide datapath: load, ITER step cycles,
// then a one-cycle completion pulse. Iterations are tracked with a Johnson counter.
module multdiv_sequencer #(
  parameter int unsigned ITER = 32,
  parameter int unsigned JW   = ITER / 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ctrl_MULT,
  input  logic          ctrl_DIV,
  input  logic          divisor_zero,
  input  logic          dp_overflow,
  output logic          dp_load,
  output logic          dp_step,
  output logic          dp_is_div,
  output logic [JW-1:0] jcount,
  output logic          busy,
  output logic          data_resultRDY,
  output logic          data_exception
);

  // Johnson pattern of the final step (state index ITER-1): MSB set, rest clear
  localparam logic [JW-1:0] JLAST = JW'(1) << (JW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      jcount         <= '0;
      dp_load        <= 1'b0;
      dp_step        <= 1'b0;
      dp_is_div      <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      dp_load        <= 1'b0;
      dp_step        <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      case (state)
        IDLE: begin
          // Multiply has priority when both start pulses coincide
          if (ctrl_MULT || ctrl_DIV) begin
            state     <= LOAD;
            dp_is_div <= !ctrl_MULT;
            jcount    <= '0;
            dp_load   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (dp_is_div && divisor_zero) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_exception <= 1'b1;
          end else begin
            state   <= RUN;
            dp_step <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          jcount <= {jcount[JW-2:0], ~jcount[JW-1]};
          if (jcount == JLAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_exception <= !dp_is_div && dp_overflow;
          end else begin
            dp_step <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: table of single-operation scenarios plus
// hand-written reset sequences.
module tb_multdiv_sequencer;

  localparam int unsigned ITER = 32;
  localparam int unsigned JW   = ITER / 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_MULT;
  logic          ctrl_DIV;
  logic          divisor_zero;
  logic          dp_overflow;
  logic          dp_load;
  logic          dp_step;
  logic          dp_is_div;
  logic [JW-1:0] jcount;
  logic          busy;
  logic          data_resultRDY;
  logic          data_exception;

  int checks   = 0;
  int failures = 0;

  multdiv_sequencer #(.ITER(ITER), .JW(JW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .dp_overflow    (dp_overflow),
    .dp_load        (dp_load),
    .dp_step        (dp_step),
    .dp_is_div      (dp_is_div),
    .jcount         (jcount),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  // op codes: 0 none, 1 mult, 2 div, 3 both
  typedef struct {
    int op0;
    int dz;
    int ovf_cyc;
    int op2;
    int op2_cyc;
    int exp_steps;
    int exp_rdy;
    int exp_exc;
    int exp_busy;
    int exp_div;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_load"}, int'(dp_load), 0);
    check({tag, "_step"}, int'(dp_step), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_rdy"}, int'(data_resultRDY), 0);
    check({tag, "_exc"}, int'(data_exception), 0);
    check({tag, "_isdiv"}, int'(dp_is_div), 0);
    check({tag, "_jcount"}, int'(jcount), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_load = 0, load_cyc = -1, n_step = 0, first_step = -1;
    int n_busy = 0, first_busy = -1, n_rdy = 0, rdy_cyc = -1, exc = -1;
    int spur = 0, div_err = 0, jerr = 0;
    logic [JW-1:0] jexp = '0;
    string t = $sformatf("v%0d", idx);
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (dp_load) begin n_load++; load_cyc = cyc; end
      if (dp_step) begin
        if (n_step == 0) first_step = cyc;
        n_step++;
        if (jcount !== jexp) jerr++;
        jexp = {jexp[JW-2:0], ~jexp[JW-1]};
      end
      if (busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (data_resultRDY) begin
        n_rdy++; rdy_cyc = cyc; exc = int'(data_exception);
      end else if (data_exception) spur++;
      if (cyc >= 1 && cyc <= v.exp_rdy && dp_is_div !== 1'(v.exp_div)) div_err++;
      ctrl_MULT    = (cyc == 0 && (v.op0 & 1) != 0) || (cyc == v.op2_cyc && (v.op2 & 1) != 0);
      ctrl_DIV     = (cyc == 0 && (v.op0 & 2) != 0) || (cyc == v.op2_cyc && (v.op2 & 2) != 0);
      divisor_zero = (v.dz != 0);
      dp_overflow  = (cyc == v.ovf_cyc);
      step_clk();
    end
    ctrl_MULT = 0; ctrl_DIV = 0; divisor_zero = 0; dp_overflow = 0;
    check({t, "_nload"}, n_load, 1);
    check({t, "_loadcyc"}, load_cyc, 1);
    check({t, "_nstep"}, n_step, v.exp_steps);
    if (v.exp_steps > 0) check({t, "_firststep"}, first_step, 2);
    check({t, "_nrdy"}, n_rdy, 1);
    check({t, "_rdycyc"}, rdy_cyc, v.exp_rdy);
    check({t, "_exc"}, exc, v.exp_exc);
    check({t, "_nbusy"}, n_busy, v.exp_busy);
    check({t, "_firstbusy"}, first_busy, 1);
    check({t, "_jcount_err"}, jerr, 0);
    check({t, "_spurious_exc"}, spur, 0);
    check({t, "_isdiv_err"}, div_err, 0);
  endtask

  initial begin
    int n_rdy, rdy_cyc;
    //         op0 dz ovf op2 op2c steps rdy exc busy div
    vecs[0] = '{1, 0, -1, 0, -1, 32, 34, 0, 33, 0};  // plain multiply
    vecs[1] = '{2, 1, -1, 0, -1,  0,  2, 1,  1, 1};  // divide by zero
    vecs[2] = '{1, 0, 33, 0, -1, 32, 34, 1, 33, 0};  // overflow on final step
    vecs[3] = '{1, 0, 20, 0, -1, 32, 34, 0, 33, 0};  // overflow mid-run ignored
    vecs[4] = '{1, 0, 32, 0, -1, 32, 34, 0, 33, 0};  // overflow one step early
    vecs[5] = '{2, 0, 33, 0, -1, 32, 34, 0, 33, 1};  // divide ignores overflow
    vecs[6] = '{2, 0, -1, 1, 10, 32, 34, 0, 33, 1};  // mult while busy dropped
    vecs[7] = '{3, 0, -1, 0, -1, 32, 34, 0, 33, 0};  // both: multiply wins
    vecs[8] = '{1, 0, -1, 2, 34, 32, 34, 0, 33, 0};  // start in DONE ignored

    reset = 1; ctrl_MULT = 0; ctrl_DIV = 0; divisor_zero = 0; dp_overflow = 0;
    repeat (3) step_clk();
    check_idle_outputs("reset");
    reset = 0;
    step_clk();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      step_clk();
    end

    // Reset in cycle 15 of a multiply, then a fresh divide at cycle 17
    n_rdy = 0; rdy_cyc = -1;
    for (int cyc = 0; cyc <= 60; cyc++) begin
      if (data_resultRDY) begin n_rdy++; rdy_cyc = cyc; end
      if (cyc == 16) check_idle_outputs("midreset");
      if (cyc == 35) check("midreset_divbusy", int'(busy), 1);
      ctrl_MULT = (cyc == 0);
      ctrl_DIV  = (cyc == 17);
      reset     = (cyc == 15);
      step_clk();
    end
    ctrl_DIV = 0;
    check("midreset_nrdy", n_rdy, 1);
    check("midreset_rdycyc", rdy_cyc, 51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
